// File: rtl/clk_tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_tap_pkg
//  Description : Shared types, constants and helpers for the tap sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_tap_pkg;

    // Default number of taps in the divider chain
    localparam int C_CNT_W = 4;

    // Sequencer states: STOP (idle, counter cleared), RUN (counting),
    // PEND (counting with a config waiting for the next wrap)
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // AND of the taps selected by mask; an empty mask yields 0.
    // Operands are zero-extended to 32 bits so any tap count up to 32 fits.
    function automatic logic masked_and(input logic [31:0] taps,
                                        input logic [31:0] mask);
        return (mask != 32'd0) && (&(taps | ~mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_tap_sequencer_tap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tap_counter
//  Description : Free-running tap counter with enable, synchronous clear and
//                one-cycle tick pulses, one per tap, after each tap rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_counter
    import clk_tap_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_tick;
    logic             r_arm;   // current count value has not been ticked yet
    logic [CNT_W-1:0] w_hit;   // tap i has just risen: bit i set, lower bits clear

    generate
        for (genvar i = 0; i < CNT_W; i++) begin : g_hit
            if (i == 0) begin : g_lsb
                assign w_hit[i] = r_cnt[0];
            end else begin : g_upper
                assign w_hit[i] = r_cnt[i] & (r_cnt[i-1:0] == '0);
            end
        end
    endgenerate

    // Count on enable; the tick for a freshly reached value is issued on the
    // next enabled cycle, and ticks are suppressed while frozen or cleared.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt  <= '0;
            r_tick <= '0;
            r_arm  <= 1'b0;
        end else if (en) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= r_arm ? w_hit : '0;
            r_arm  <= 1'b1;
        end else begin
            r_tick <= '0;
        end
    end

    assign cnt  = r_cnt;
    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : clk_tap_sequencer
//  Description : Synchronous divide-by-2^(i+1) tap chain with a masked AND
//                output; a valid/ready port starts, stops and reprograms the
//                mask, with changes while running deferred to counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_tap_sequencer
    import clk_tap_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_run,
    input  logic [CNT_W-1:0] cfg_mask,
    output logic [CNT_W-1:0] div_out,
    output logic [CNT_W-1:0] tick,
    output logic             y_out,
    output logic             running
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_mask;
    logic [CNT_W-1:0] w_mask_nxt;
    logic [CNT_W-1:0] r_pend_mask;
    logic [CNT_W-1:0] w_pend_mask_nxt;
    logic             r_pend_run;
    logic             w_pend_run_nxt;

    logic [CNT_W-1:0] w_cnt;
    logic             w_accept;
    logic             w_cnt_full;
    logic             w_count_en;
    logic             w_stop_apply;
    logic             w_clr;

    assign cfg_ready    = ~reset & (r_state != ST_PEND);
    assign w_accept     = cfg_valid & cfg_ready;
    assign w_cnt_full   = &w_cnt;
    assign w_count_en   = (r_state != ST_STOP) & ena;
    // A pending stop lands on the wrap edge: the counter and ticks clear there
    assign w_stop_apply = (r_state == ST_PEND) & ena & w_cnt_full & ~r_pend_run;
    assign w_clr        = (r_state == ST_STOP) | w_stop_apply;

    tap_counter #(
        .CNT_W (CNT_W)
    ) u_tap_counter (
        .clk   (clk),
        .reset (reset),
        .en    (w_count_en),
        .clr   (w_clr),
        .cnt   (w_cnt),
        .tick  (tick)
    );

    // State and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_STOP;
            r_mask      <= '0;
            r_pend_mask <= '0;
            r_pend_run  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_pend_mask <= w_pend_mask_nxt;
            r_pend_run  <= w_pend_run_nxt;
        end
    end

    // Next-state: immediate apply when stopped, deferred apply while running
    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_pend_mask_nxt = r_pend_mask;
        w_pend_run_nxt  = r_pend_run;
        case (r_state)
            ST_STOP: begin
                if (w_accept) begin
                    w_mask_nxt = cfg_mask;
                    if (cfg_run) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_pend_mask_nxt = cfg_mask;
                    w_pend_run_nxt  = cfg_run;
                    w_state_nxt     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (ena && w_cnt_full) begin
                    w_mask_nxt  = r_pend_mask;
                    w_state_nxt = r_pend_run ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    assign div_out = w_cnt;
    assign y_out   = masked_and(32'(w_cnt), 32'(r_mask));
    assign running = (r_state == ST_RUN) | (r_state == ST_PEND);

endmodule
`default_nettype wire

// File: tb/tb_clk_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_tap_sequencer
//  Description : Self-checking bench for clk_tap_sequencer: table vectors,
//                directed corner sequences and random stimulus against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_tap_sequencer;

    localparam int CNT_W = 4;
    localparam int N     = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             ena;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_run;
    logic [CNT_W-1:0] cfg_mask;
    logic [CNT_W-1:0] div_out;
    logic [CNT_W-1:0] tick;
    logic             y_out;
    logic             running;

    int n_tests = 0;
    int n_fail  = 0;

    clk_tap_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_run   (cfg_run),
        .cfg_mask  (cfg_mask),
        .div_out   (div_out),
        .tick      (tick),
        .y_out     (y_out),
        .running   (running)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // m_state: 0 = stopped, 1 = running, 2 = running with config waiting
    int m_state, m_cnt, m_mask, m_pmask, m_prun, m_tick, m_fresh;

    // A value v raises exactly the tap at its lowest set bit
    function automatic int tick_of(input int v);
        for (int b = 0; b < CNT_W; b++) begin
            if (((v >> b) & 1) == 1) return (1 << b);
        end
        return 0;
    endfunction

    function automatic bit model_y();
        return (m_mask != 0) && ((m_cnt & m_mask) == m_mask);
    endfunction

    task automatic model_step(input bit a_rst, input bit a_ena, input bit a_v,
                              input bit a_run, input int a_msk);
        bit acc;
        bit at_top;
        if (a_rst) begin
            m_state = 0; m_cnt = 0; m_mask = 0; m_pmask = 0; m_prun = 0;
            m_tick = 0; m_fresh = -1;
            return;
        end
        acc    = a_v && (m_state != 2);
        at_top = (m_cnt == N - 1);
        if (m_state == 0) begin
            m_tick = 0; m_cnt = 0; m_fresh = -1;
            if (acc) begin
                m_mask = a_msk;
                if (a_run) m_state = 1;
            end
        end else if (!a_ena) begin
            m_tick = 0;
            if (acc) begin
                m_pmask = a_msk; m_prun = a_run; m_state = 2;
            end
        end else begin
            m_tick  = (m_fresh >= 0) ? tick_of(m_fresh) : 0;
            m_cnt   = (m_cnt + 1) % N;
            m_fresh = m_cnt;
            if (m_state == 2 && at_top) begin
                m_mask = m_pmask;
                if (m_prun != 0) begin
                    m_state = 1;
                end else begin
                    m_state = 0; m_tick = 0; m_fresh = -1;
                end
            end else if (acc) begin
                m_pmask = a_msk; m_prun = a_run; m_state = 2;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare
    task automatic cycle(input bit a_rst, input bit a_ena, input bit a_v,
                         input bit a_run, input logic [3:0] a_msk);
        logic [10:0] exp_v, act_v;
        reset = a_rst; ena = a_ena; cfg_valid = a_v; cfg_run = a_run; cfg_mask = a_msk;
        @(posedge clk);
        model_step(a_rst, a_ena, a_v, a_run, int'(a_msk));
        #1;
        exp_v = {~a_rst & (m_state != 2), m_state != 0, model_y(),
                 4'(m_cnt), 4'(m_tick)};
        act_v = {cfg_ready, running, y_out, div_out, tick};
        chk("model_cycle{ready,running,y,div,tick}", 32'(act_v), 32'(exp_v));
    endtask

    // Idle-run until the model reaches the wanted state/count, bounded
    task automatic steer(input int st, input int cn, input string name);
        int k;
        k = 0;
        while (!(m_state == st && m_cnt == cn) && k < 40) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
            k++;
        end
        chk({"steer_", name}, 32'(k < 40), 32'd1);
    endtask

    // ---------------- table vectors ----------------
    typedef struct packed {
        logic       rst, en, v, run;
        logic [3:0] msk;
        logic [3:0] e_div, e_tick;
        logic       e_y, e_rdy, e_run;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(bit r, bit e, bit v, bit ru, logic [3:0] m,
                                logic [3:0] d, logic [3:0] t, bit y, bit rdy, bit rn);
        vec_t x;
        x.rst = r; x.en = e; x.v = v; x.run = ru; x.msk = m;
        x.e_div = d; x.e_tick = t; x.e_y = y; x.e_rdy = rdy; x.e_run = rn;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a request present, then start mask=0101 and count
        vecs[0]  = mk(1, 1, 1, 1, 4'h5, 4'h0, 4'h0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 1, 4'h5, 4'h0, 4'h0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 1, 1, 4'h5, 4'h0, 4'h0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 4'h5, 4'h0, 4'h0, 0, 1, 0);
        vecs[4]  = mk(0, 1, 1, 1, 4'h5, 4'h0, 4'h0, 0, 1, 1);
        vecs[5]  = mk(0, 1, 0, 0, 4'h0, 4'h1, 4'h0, 0, 1, 1);
        vecs[6]  = mk(0, 1, 0, 0, 4'h0, 4'h2, 4'h1, 0, 1, 1);
        vecs[7]  = mk(0, 1, 0, 0, 4'h0, 4'h3, 4'h2, 0, 1, 1);
        vecs[8]  = mk(0, 1, 0, 0, 4'h0, 4'h4, 4'h1, 0, 1, 1);
        vecs[9]  = mk(0, 1, 0, 0, 4'h0, 4'h5, 4'h4, 1, 1, 1);
        vecs[10] = mk(0, 1, 0, 0, 4'h0, 4'h6, 4'h1, 0, 1, 1);
        vecs[11] = mk(0, 1, 0, 0, 4'h0, 4'h7, 4'h2, 1, 1, 1);
        vecs[12] = mk(0, 1, 0, 0, 4'h0, 4'h8, 4'h1, 0, 1, 1);
        vecs[13] = mk(0, 1, 0, 0, 4'h0, 4'h9, 4'h8, 0, 1, 1);

        reset = 1'b1; ena = 1'b0; cfg_valid = 1'b0; cfg_run = 1'b0; cfg_mask = '0;
        m_state = 0; m_cnt = 0; m_mask = 0; m_pmask = 0; m_prun = 0;
        m_tick = 0; m_fresh = -1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].v, vecs[i].run, vecs[i].msk);
            chk($sformatf("vec%0d{div,tick,y,ready,running}", i),
                32'({div_out, tick, y_out, cfg_ready, running}),
                32'({vecs[i].e_div, vecs[i].e_tick, vecs[i].e_y, vecs[i].e_rdy, vecs[i].e_run}));
        end

        // Reprogram at cnt=3: old mask to the wrap, new mask 1000 from cnt 0
        steer(1, 3, "run_cnt3");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h8);
        chk("ready_drops_in_pend", 32'(cfg_ready), 32'd0);
        steer(1, 0, "apply_wrap");
        chk("ready_back_after_apply", 32'(cfg_ready), 32'd1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("mask1000_y_at_%0d", m_cnt), 32'(y_out), 32'(m_cnt >= 8));
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        end

        // Stop request at cnt=6: counts on to 15, then stops at 0
        steer(1, 6, "run_cnt6");
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h3);
        steer(0, 0, "stopped");
        chk("stop_outputs{running,div,y,tick}",
            32'({running, div_out, y_out, tick}), 32'd0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("stop_holds_div", 32'(div_out), 32'd0);

        // Start with ena=0 in STOP, then freeze at all-ones while pending
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
        chk("start_with_ena0", 32'(running), 32'd1);
        steer(1, 2, "run_cnt2");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h6);
        steer(2, 15, "pend_cnt15");
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h9);
            chk("freeze_div_tick", 32'({div_out, tick}), 32'({4'hF, 4'h0}));
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("apply_after_freeze{running,ready,div}",
            32'({running, cfg_ready, div_out}), 32'({1'b1, 1'b1, 4'h0}));

        // Accept exactly at the wrap: normal wrap, config stays pending
        steer(1, 15, "run_cnt15");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hC);
        chk("wrap_accept_pending", 32'({cfg_ready, div_out}), 32'({1'b0, 4'h0}));

        // Reset in PEND at cnt=10 discards the pending config
        steer(2, 10, "pend_cnt10");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("reset_in_pend{ready,running,y,div,tick}",
            32'({cfg_ready, running, y_out, div_out, tick}), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("restart_from_zero", 32'(div_out), 32'd1);

        // Random stimulus against the model
        for (int k = 0; k < 800; k++) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0,
                  4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
